// File: rtl/pulse_shaper_pkg.sv
// Shared types and constants for the N-channel detector pulse shaper.
// Optional drop counters are enabled by defining PULSE_SHAPER_DROP_CNT_EN.
package pulse_shaper_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        PULSE = ST_PULSE,
        DEAD  = ST_DEAD
    } state_t;

    localparam int DROP_CNT_W     = 16;
    localparam int PS_DEF_N_CH    = 4;
    localparam int PS_DEF_CNT_W   = 8;
    localparam int PS_DEF_SYNC    = 2;
    localparam int PS_DEF_WIDTH   = 1;
    localparam int PS_DEF_DEAD    = 30;

endpackage

// File: rtl/pulse_shaper_if.sv
// Handshake-free bundle between the shaper array and its controller.
// drop_cnt/drop_clr exist only when PULSE_SHAPER_DROP_CNT_EN is defined.
interface pulse_shaper_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    import pulse_shaper_pkg::*;

    logic [N_CH-1:0]  ch_in;
    logic             enable;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_dead;
    logic             cfg_load;
    logic [N_CH-1:0]  pulse_out;
    logic [N_CH-1:0]  busy;
`ifdef PULSE_SHAPER_DROP_CNT_EN
    logic                       drop_clr;
    logic [N_CH*DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output ch_in, enable, cfg_width, cfg_dead, cfg_load, drop_clr,
        input  pulse_out, busy, drop_cnt
    );
    modport slave (
        input  ch_in, enable, cfg_width, cfg_dead, cfg_load, drop_clr,
        output pulse_out, busy, drop_cnt
    );
`else
    modport master (
        output ch_in, enable, cfg_width, cfg_dead, cfg_load,
        input  pulse_out, busy
    );
    modport slave (
        input  ch_in, enable, cfg_width, cfg_dead, cfg_load,
        output pulse_out, busy
    );
`endif

endinterface

// File: rtl/pulse_shaper_channel.sv
// One shaper channel: synchroniser, rising-edge detect, PULSE/DEAD FSM.
// Drop counter present only with PULSE_SHAPER_DROP_CNT_EN.
module pulse_shaper_channel
    import pulse_shaper_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      width,
    input  logic [CNT_W-1:0]      dead,
`ifdef PULSE_SHAPER_DROP_CNT_EN
    input  logic                  drop_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic                  pulse,
    output logic                  busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic                   accept;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       dead_q;

    // Reset to 1 so a level already high at reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign accept = rise & enable & (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            dead_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_PULSE;
                        cnt_q  <= (width == '0) ? '0 : width - 1'b1;
                        dead_q <= dead;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (dead_q != '0) begin
                        state <= ST_DEAD;
                        cnt_q <= dead_q - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else             state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse <= 1'b0;
            busy  <= 1'b0;
        end else begin
            pulse <= (state == ST_PULSE);
            busy  <= (state != ST_IDLE);
        end
    end

`ifdef PULSE_SHAPER_DROP_CNT_EN
    logic                  reject;
    logic [DROP_CNT_W-1:0] drop_q;

    assign reject = rise & ~accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_q <= '0;
        else if (drop_clr)
            drop_q <= '0;
        else if (reject && drop_q != '1)
            drop_q <= drop_q + 1'b1;
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: rtl/pulse_shaper_array.sv
// N-channel detector pulse shaper: shadow config registers plus channels.
// Define PULSE_SHAPER_DROP_CNT_EN to add per-channel rejected-edge counters.
module pulse_shaper_array
    import pulse_shaper_pkg::*;
#(
    parameter int N_CH        = PS_DEF_N_CH,
    parameter int CNT_W       = PS_DEF_CNT_W,
    parameter int SYNC_STAGES = PS_DEF_SYNC,
    parameter int DEF_WIDTH   = PS_DEF_WIDTH,
    parameter int DEF_DEAD    = PS_DEF_DEAD
) (
    input  logic         clk,
    input  logic         rst,
    pulse_shaper_if.slave bus
);

    logic [CNT_W-1:0] width_sh;
    logic [CNT_W-1:0] dead_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_sh <= CNT_W'(DEF_WIDTH);
            dead_sh  <= CNT_W'(DEF_DEAD);
        end else if (bus.cfg_load) begin
            width_sh <= bus.cfg_width;
            dead_sh  <= bus.cfg_dead;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pulse_shaper_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .din      (bus.ch_in[k]),
            .enable   (bus.enable),
            .width    (width_sh),
            .dead     (dead_sh),
`ifdef PULSE_SHAPER_DROP_CNT_EN
            .drop_clr (bus.drop_clr),
            .drop_cnt (bus.drop_cnt[DROP_CNT_W*k +: DROP_CNT_W]),
`endif
            .pulse    (bus.pulse_out[k]),
            .busy     (bus.busy[k])
        );
    end

endmodule

// File: tb/tb_pulse_shaper_array.sv
// Scoreboard bench for pulse_shaper_array; drop-counter scenarios are
// compiled only when PULSE_SHAPER_DROP_CNT_EN is defined.
module tb_pulse_shaper_array;
    import pulse_shaper_pkg::*;

    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int SS  = 2;
    localparam int LAT = SS + 2;

    typedef struct {
        int ch;
        int start;
        int width;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pulse_shaper_if #(.N_CH(N), .CNT_W(CW)) bus ();

    pulse_shaper_array #(
        .N_CH        (N),
        .CNT_W       (CW),
        .SYNC_STAGES (SS),
        .DEF_WIDTH   (1),
        .DEF_DEAD    (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each completed pulse is matched to the oldest expectation on its channel.
    logic [N-1:0] mon_prev = '0;
    int           mon_start [N];
    always @(negedge clk) begin
        int idx;
        for (int k = 0; k < N; k++) begin
            if (bus.pulse_out[k] && !mon_prev[k]) mon_start[k] = cyc;
            if (!bus.pulse_out[k] && mon_prev[k]) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].ch == k) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected ch%0d: got start %0d width %0d, required no pulse",
                             k, mon_start[k], cyc - mon_start[k]);
                end else begin
                    if (mon_start[k] !== sb[idx].start) begin
                        errors++;
                        $display("FAIL pulse_start ch%0d: got %0d, required %0d",
                                 k, mon_start[k], sb[idx].start);
                    end
                    checks++;
                    if ((cyc - mon_start[k]) !== sb[idx].width) begin
                        errors++;
                        $display("FAIL pulse_width ch%0d: got %0d, required %0d",
                                 k, cyc - mon_start[k], sb[idx].width);
                    end
                    sb.delete(idx);
                end
            end
        end
        mon_prev = bus.pulse_out;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int ch, input int w);
        exp_t e;
        e.ch    = ch;
        e.start = cyc + LAT;
        e.width = w;
        sb.push_back(e);
    endtask

    // One-cycle high on the masked inputs; w=0 means the edge must be rejected.
    task automatic fire(input logic [N-1:0] m, input int w);
        for (int k = 0; k < N; k++)
            if (m[k] && w > 0) push_exp(k, w);
        bus.ch_in = bus.ch_in | m;
        tick(1);
        bus.ch_in = bus.ch_in & ~m;
    endtask

    task automatic load_cfg(input int w, input int d);
        bus.cfg_width = CW'(w);
        bus.cfg_dead  = CW'(d);
        bus.cfg_load  = 1'b1;
        tick(1);
        bus.cfg_load  = 1'b0;
    endtask

    task automatic drain(output int left);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy != '0) && n < 400) begin
            tick(1);
            n++;
        end
        tick(2);
        left = sb.size();
    endtask

    task automatic test_reset();
        int left;
        rst = 1'b1;
        bus.ch_in = 4'b0001;
        tick(3);
        checks++;
        if (bus.pulse_out !== '0) begin
            errors++;
            $display("FAIL reset_pulse: got %b, required 0000", bus.pulse_out);
        end
        checks++;
        if (bus.busy !== '0) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 0000", bus.busy);
        end
`ifdef PULSE_SHAPER_DROP_CNT_EN
        checks++;
        if (bus.drop_cnt !== '0) begin
            errors++;
            $display("FAIL reset_drop: got %h, required 0", bus.drop_cnt);
        end
`endif
        rst = 1'b0;
        tick(12);
        checks++;
        if (bus.busy !== '0) begin
            errors++;
            $display("FAIL held_high_trigger: busy %b, required 0000", bus.busy);
        end
        bus.ch_in[0] = 1'b0;
        tick(3);
        push_exp(0, 1);
        bus.ch_in[0] = 1'b1;
        tick(3);
        bus.ch_in[0] = 1'b0;
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL reset_missing: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_width_dead();
        int left;
        int bcnt;
        int other;
        bcnt  = 0;
        other = 0;
        load_cfg(4, 10);
        tick(2);
        fire(4'b0010, 4);
        repeat (40) begin
            tick(1);
            if (bus.busy[1]) bcnt++;
            if ((bus.busy & 4'b1101) != '0) other++;
        end
        checks++;
        if (bcnt !== 14) begin
            errors++;
            $display("FAIL busy_len: got %0d, required 14", bcnt);
        end
        checks++;
        if (other !== 0) begin
            errors++;
            $display("FAIL other_busy: got %0d cycles, required 0", other);
        end
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL wd_missing: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_dead_reject();
        int left;
        logic [15:0] base;
        base = '0;
        load_cfg(2, 10);
        tick(2);
`ifdef PULSE_SHAPER_DROP_CNT_EN
        base = bus.drop_cnt[15:0];
`endif
        for (int i = 0; i < 4; i++) begin
            fire(4'b0001, (i % 2 == 0) ? 2 : 0);
            tick(4);
`ifdef PULSE_SHAPER_DROP_CNT_EN
            checks++;
            if (bus.drop_cnt[15:0] !== 16'(base + (i + 1) / 2)) begin
                errors++;
                $display("FAIL drop_dead edge%0d: got %0d, required %0d",
                         i, bus.drop_cnt[15:0], base + (i + 1) / 2);
            end
`endif
            tick(3);
        end
        drain(left);
        checks++;
        if (left !== 0 || base !== base) begin
            errors++;
            $display("FAIL dead_missing: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_cfg_midpulse();
        int left;
        load_cfg(3, 0);
        tick(2);
        fire(4'b0100, 3);
        tick(LAT);
        load_cfg(6, 0);
        drain(left);
        fire(4'b0100, 6);
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL cfg_missing: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_enable();
        int left;
        logic [N*16-1:0] base;
        base = '0;
        bus.enable = 1'b0;
        load_cfg(2, 3);
        tick(2);
`ifdef PULSE_SHAPER_DROP_CNT_EN
        base = bus.drop_cnt;
`endif
        fire(4'b1111, 0);
        tick(6);
        checks++;
        if (bus.busy !== '0) begin
            errors++;
            $display("FAIL disabled_busy: got %b, required 0000", bus.busy);
        end
`ifdef PULSE_SHAPER_DROP_CNT_EN
        for (int k = 0; k < N; k++) begin
            checks++;
            if (bus.drop_cnt[16*k +: 16] !== 16'(base[16*k +: 16] + 1)) begin
                errors++;
                $display("FAIL drop_enable ch%0d: got %0d, required %0d",
                         k, bus.drop_cnt[16*k +: 16], base[16*k +: 16] + 1);
            end
        end
`endif
        bus.enable = 1'b1;
        tick(2);
        fire(4'b1111, 2);
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL enable_missing: got %0d pending, required 0", left);
        end
    endtask

    task automatic test_back_to_back();
        int left;
        load_cfg(0, 0);
        tick(2);
        repeat (6) begin
            fire(4'b1000, 1);
            tick(1);
        end
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL b2b_missing: got %0d pending, required 0", left);
        end
    endtask

`ifdef PULSE_SHAPER_DROP_CNT_EN
    task automatic test_saturate();
        bus.enable = 1'b0;
        tick(2);
        force dut.g_ch[0].u_ch.drop_q = 16'hFFFF;
        tick(1);
        release dut.g_ch[0].u_ch.drop_q;
        fire(4'b0001, 0);
        tick(5);
        checks++;
        if (bus.drop_cnt[15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_sat: got %h, required ffff", bus.drop_cnt[15:0]);
        end
        fire(4'b0001, 0);
        tick(1);
        bus.drop_clr = 1'b1;
        tick(1);
        bus.drop_clr = 1'b0;
        tick(2);
        checks++;
        if (bus.drop_cnt[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL drop_clr: got %h, required 0000", bus.drop_cnt[15:0]);
        end
        bus.enable = 1'b1;
        tick(2);
    endtask
`endif

    task automatic test_async_reset();
        int left;
        load_cfg(2, 20);
        tick(2);
        fire(4'b0010, 2);
        tick(10);
        checks++;
        if (bus.busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL dead_busy: got %b, required 1", bus.busy[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== '0 || bus.pulse_out !== '0) begin
            errors++;
            $display("FAIL async_rst: got busy %b pulse %b, required 0000 0000",
                     bus.busy, bus.pulse_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        fire(4'b0010, 1);
        drain(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL rst_missing: got %0d pending, required 0", left);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.ch_in     = '0;
        bus.enable    = 1'b1;
        bus.cfg_width = '0;
        bus.cfg_dead  = '0;
        bus.cfg_load  = 1'b0;
`ifdef PULSE_SHAPER_DROP_CNT_EN
        bus.drop_clr  = 1'b0;
`endif
        test_reset();
        test_width_dead();
        test_dead_reject();
        test_cfg_midpulse();
        test_enable();
        test_back_to_back();
`ifdef PULSE_SHAPER_DROP_CNT_EN
        test_saturate();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
